// File: rtl/tcdm_resp_bank.sv
// Single-port TCDM bank: same-cycle grant, registered one-cycle-later response with byte-enable writes.
// Optional grant-stall pattern generator enabled by defining TCDM_RESP_BANK_STALL_EN.
module tcdm_resp_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NB_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    tcdm_req_i,
    input  logic [31:0]             tcdm_add_i,
    input  logic                    tcdm_wen_i,
    input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
    output logic                    tcdm_gnt_o,
    output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
    output logic                    tcdm_r_valid_o,
    input  logic [7:0]              stall_pattern_i,
    output logic [15:0]             rd_cnt_o,
    output logic [15:0]             wr_cnt_o,
    output logic                    err_o
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned IDX_W = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
    localparam logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(32'hDEAD_BEEF);
    localparam logic [31:0]           ALIGN_MASK = 32'(BE_W - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    logic stall;

`ifdef TCDM_RESP_BANK_STALL_EN
    logic [7:0] stall_q, stall_d;

    always_comb begin
        stall_d = {stall_q[6:0], stall_q[7]};
        if (clear_i) stall_d = stall_pattern_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_q <= 8'h00;
        else       stall_q <= stall_d;
    end

    assign stall = stall_q[0];
`else
    logic unused_stall_pattern;
    assign unused_stall_pattern = ^stall_pattern_i;
    assign stall = 1'b0;
`endif

    logic [31:0]      byte_off;
    logic [31:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             oor;
    logic             rd_gnt;
    logic             wr_gnt;

    // Alignment is checked on the raw address so a misaligned BASE_ADDR cannot mask it.
    assign byte_off = tcdm_add_i - BASE_ADDR;
    assign word_off = byte_off >> OFF_W;
    assign idx      = word_off[IDX_W-1:0];
    assign oor      = (tcdm_add_i < BASE_ADDR) || (word_off >= 32'(NB_WORDS)) ||
                      ((tcdm_add_i & ALIGN_MASK) != 32'd0);

    assign tcdm_gnt_o = tcdm_req_i & ~stall & ~clear_i & ~rst_i;
    assign rd_gnt     = tcdm_gnt_o &  tcdm_wen_i;
    assign wr_gnt     = tcdm_gnt_o & ~tcdm_wen_i;

    logic [DATA_WIDTH-1:0] mem_q [NB_WORDS];

    always_ff @(posedge clk_i) begin
        if (wr_gnt && !oor) begin
            for (int b = 0; b < BE_W; b++) begin
                if (tcdm_be_i[b]) mem_q[idx][8*b +: 8] <= tcdm_data_i[8*b +: 8];
            end
        end
    end

    logic                  r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0] r_data_q,  r_data_d;
    logic [15:0]           rd_cnt_q,  rd_cnt_d;
    logic [15:0]           wr_cnt_q,  wr_cnt_d;
    logic                  err_q,     err_d;

    always_comb begin
        r_valid_d = tcdm_gnt_o;
        r_data_d  = '0;
        if (tcdm_gnt_o && oor) r_data_d = ERR_DATA;
        else if (rd_gnt)       r_data_d = mem_q[idx];
        rd_cnt_d = sat_inc(rd_cnt_q, rd_gnt);
        wr_cnt_d = sat_inc(wr_cnt_q, wr_gnt);
        err_d    = err_q | (tcdm_gnt_o & oor);
        if (clear_i) begin
            r_valid_d = 1'b0;
            r_data_d  = '0;
            rd_cnt_d  = '0;
            wr_cnt_d  = '0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_q     <= err_d;
        end
    end

    assign tcdm_r_valid_o = r_valid_q;
    assign tcdm_r_data_o  = r_data_q;
    assign rd_cnt_o       = rd_cnt_q;
    assign wr_cnt_o       = wr_cnt_q;
    assign err_o          = err_q;

endmodule
